// File: rtl/linear_sensor_ctrl.sv
// linear_sensor_ctrl
// Multi-frame controller for a G11620-class linear image sensor.
// A start edge reads three config words: integration time, pixel count and
// frame count. The controller then runs integrate / wait-for-ad_sp / readout /
// blank frames and emits the ADC samples as an indexed, valid-tagged stream.
//
// Optional feature: define LINEAR_SENSOR_SP_TIMEOUT_EN to add an ad_sp timeout.
// With it, WAIT_SP gives up after SP_TIMEOUT clocks, raises the sticky err_o
// and returns to IDLE without done_o. Without it, WAIT_SP waits indefinitely
// and err_o stays 0.
//
// Output timing:
//   sensor_reset_o, frame_done_o and done_o are registered from the next
//   state, so they line up exactly with the INTEG cycles, the final BLANK
//   cycle and the DONE cycle.
//   The pixel outputs are registered from the DATA cycle that sampled
//   adc_data, so they lag that cycle by one clock.
//   cfg_ram_rd_o and cfg_ram_addr_o are decoded from registered state, so the
//   read data arrives exactly one clock after each strobe.
`timescale 1ns/1ps

module linear_sensor_ctrl #(
    parameter int         MAX_PIX    = 512,
    parameter int         PIX_W      = 10,
    parameter int         ADC_W      = 16,
    parameter int         BLANK_CYC  = 24,
    parameter logic [7:0] CFG_BASE   = 8'h01,
    parameter int         SP_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             soft_reset_in,
    input  logic             ad_sp,
    input  logic [ADC_W-1:0] adc_data,
    output logic             sensor_clk,
    output logic             sensor_reset_o,
    output logic             cfg_ram_rd_o,
    output logic [7:0]       cfg_ram_addr_o,
    input  logic [31:0]      cfg_ram_din,
    output logic             pix_valid_o,
    output logic [ADC_W-1:0] pix_data_o,
    output logic [PIX_W-1:0] pix_idx_o,
    output logic             pix_last_o,
    output logic             frame_done_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o
);

`ifdef LINEAR_SENSOR_SP_TIMEOUT_EN
    localparam bit SP_TO_EN = 1'b1;
`else
    localparam bit SP_TO_EN = 1'b0;
`endif

    localparam logic [31:0]      BLANK_LAST  = 32'(BLANK_CYC - 1);
    localparam logic [31:0]      SP_LAST     = 32'(SP_TIMEOUT - 1);
    localparam logic [31:0]      MAX_PIX_W32 = 32'(MAX_PIX);
    localparam logic [PIX_W-1:0] MAX_PIX_CNT = PIX_W'(MAX_PIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_INTEG,
        S_WAIT_SP,
        S_DATA,
        S_BLANK,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic               start_r_reg, start_r_next;
    logic [1:0]         cfg_cnt_reg, cfg_cnt_next;
    logic [31:0]        clk_cnt_reg, clk_cnt_next;
    logic [PIX_W-1:0]   pix_cnt_idx_reg, pix_cnt_idx_next;
    logic [31:0]        frames_done_reg, frames_done_next;
    logic [31:0]        integ_time_reg, integ_time_next;
    logic [PIX_W-1:0]   pix_cnt_reg, pix_cnt_next;
    logic [31:0]        frame_cnt_reg, frame_cnt_next;

    logic               sensor_reset_reg, sensor_reset_next;
    logic               pix_valid_reg, pix_valid_next;
    logic [ADC_W-1:0]   pix_data_reg, pix_data_next;
    logic [PIX_W-1:0]   pix_idx_reg, pix_idx_next;
    logic               pix_last_reg, pix_last_next;
    logic               frame_done_reg, frame_done_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic [PIX_W-1:0]   pix_last_idx;
    logic               more_frames;

    // Index of the final pixel of a line. The pixel count is never 0 after the clamp.
    assign pix_last_idx = pix_cnt_reg - PIX_W'(1);
    // A frame count of 0 means "run until soft reset".
    assign more_frames  = (frame_cnt_reg == 32'd0) ||
                          ((frames_done_reg + 32'd1) < frame_cnt_reg);

    // State register, counters, captured config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            start_r_reg      <= 1'b0;
            cfg_cnt_reg      <= 2'd0;
            clk_cnt_reg      <= 32'd0;
            pix_cnt_idx_reg  <= '0;
            frames_done_reg  <= 32'd0;
            integ_time_reg   <= 32'd0;
            pix_cnt_reg      <= '0;
            frame_cnt_reg    <= 32'd0;
            sensor_reset_reg <= 1'b0;
            pix_valid_reg    <= 1'b0;
            pix_data_reg     <= '0;
            pix_idx_reg      <= '0;
            pix_last_reg     <= 1'b0;
            frame_done_reg   <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            start_r_reg      <= start_r_next;
            cfg_cnt_reg      <= cfg_cnt_next;
            clk_cnt_reg      <= clk_cnt_next;
            pix_cnt_idx_reg  <= pix_cnt_idx_next;
            frames_done_reg  <= frames_done_next;
            integ_time_reg   <= integ_time_next;
            pix_cnt_reg      <= pix_cnt_next;
            frame_cnt_reg    <= frame_cnt_next;
            sensor_reset_reg <= sensor_reset_next;
            pix_valid_reg    <= pix_valid_next;
            pix_data_reg     <= pix_data_next;
            pix_idx_reg      <= pix_idx_next;
            pix_last_reg     <= pix_last_next;
            frame_done_reg   <= frame_done_next;
            done_reg         <= done_next;
            err_reg          <= err_next;
        end
    end

    // Next-state, counter, config-capture and output decode.
    always_comb begin
        state_next        = state_reg;
        start_r_next      = start_in;
        cfg_cnt_next      = cfg_cnt_reg;
        clk_cnt_next      = clk_cnt_reg;
        pix_cnt_idx_next  = pix_cnt_idx_reg;
        frames_done_next  = frames_done_reg;
        integ_time_next   = integ_time_reg;
        pix_cnt_next      = pix_cnt_reg;
        frame_cnt_next    = frame_cnt_reg;
        err_next          = err_reg;

        case (state_reg)
            S_IDLE: begin
                // Only a fresh rising edge counts; a level held over from a previous run does not.
                if (start_in && !start_r_reg) begin
                    state_next       = S_CFG;
                    cfg_cnt_next     = 2'd0;
                    frames_done_next = 32'd0;
                    err_next         = 1'b0;
                end
            end

            S_CFG: begin
                // Strobes go out on cfg_cnt 0..2. Each word is captured one clock later.
                cfg_cnt_next = cfg_cnt_reg + 2'd1;
                case (cfg_cnt_reg)
                    2'd1: integ_time_next = (cfg_ram_din == 32'd0) ? 32'd1 : cfg_ram_din;
                    2'd2: begin
                        if ((cfg_ram_din == 32'd0) || (cfg_ram_din > MAX_PIX_W32))
                            pix_cnt_next = MAX_PIX_CNT;
                        else
                            pix_cnt_next = cfg_ram_din[PIX_W-1:0];
                    end
                    2'd3: begin
                        frame_cnt_next = cfg_ram_din;
                        state_next     = S_INTEG;
                        clk_cnt_next   = 32'd0;
                    end
                    default: ;
                endcase
            end

            S_INTEG: begin
                if (clk_cnt_reg == (integ_time_reg - 32'd1)) begin
                    state_next   = S_WAIT_SP;
                    clk_cnt_next = 32'd0;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 32'd1;
                end
            end

            S_WAIT_SP: begin
                // ad_sp wins over a timeout that expires on the same clock.
                if (ad_sp) begin
                    state_next       = S_DATA;
                    pix_cnt_idx_next = '0;
                end else if (SP_TO_EN && (clk_cnt_reg == SP_LAST)) begin
                    state_next = S_IDLE;
                    err_next   = 1'b1;
                end else if (SP_TO_EN) begin
                    clk_cnt_next = clk_cnt_reg + 32'd1;
                end
            end

            S_DATA: begin
                if (pix_cnt_idx_reg == pix_last_idx) begin
                    state_next   = S_BLANK;
                    clk_cnt_next = 32'd0;
                end else begin
                    pix_cnt_idx_next = pix_cnt_idx_reg + PIX_W'(1);
                end
            end

            S_BLANK: begin
                if (clk_cnt_reg == BLANK_LAST) begin
                    frames_done_next = frames_done_reg + 32'd1;
                    clk_cnt_next     = 32'd0;
                    // Later frames reuse the captured config; it is not read again.
                    state_next       = more_frames ? S_INTEG : S_DONE;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 32'd1;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // An abort overrides every transition above, but has no effect while already idle.
        if ((state_reg != S_IDLE) && soft_reset_in)
            state_next = S_IDLE;

        // Outputs are decoded from the next state. An abort therefore clears them on the next clock.
        sensor_reset_next = (state_next == S_INTEG);
        done_next         = (state_next == S_DONE);
        frame_done_next   = (state_next == S_BLANK) && (clk_cnt_next == BLANK_LAST);

        // The pixel stream lags the DATA cycle that sampled adc_data by one clock.
        pix_valid_next = (state_reg == S_DATA) && !soft_reset_in;
        pix_data_next  = (state_reg == S_DATA) ? adc_data : pix_data_reg;
        pix_idx_next   = (state_reg == S_DATA) ? pix_cnt_idx_reg : pix_idx_reg;
        pix_last_next  = pix_valid_next && (pix_cnt_idx_reg == pix_last_idx);
    end

    assign sensor_clk     = ~clk;
    assign sensor_reset_o = sensor_reset_reg;
    assign cfg_ram_rd_o   = (state_reg == S_CFG) && (cfg_cnt_reg != 2'd3);
    assign cfg_ram_addr_o = cfg_ram_rd_o ? (CFG_BASE + {6'd0, cfg_cnt_reg}) : 8'h00;
    assign pix_valid_o    = pix_valid_reg;
    assign pix_data_o     = pix_data_reg;
    assign pix_idx_o      = pix_idx_reg;
    assign pix_last_o     = pix_last_reg;
    assign frame_done_o   = frame_done_reg;
    assign done_o         = done_reg;
    assign busy_o         = (state_reg != S_IDLE);
    assign err_o          = err_reg;

endmodule
